digi_countdown_timer: RTL and testbench
=======================================

Name: digi_countdown_timer

Overview:
- HH:MM:SS countdown timer: the down-counting counterpart of the team's up-counting digital clock, using the same 8-bit sec/min/hour output format.
- A prescaler divides clk into second ticks; each tick decrements the time by one second with borrow.
- Supports load, start, pause/resume, and a one-cycle done pulse plus a sticky expired flag at 00:00:00.
- Feeds the same display/readout logic as the clock.

Parameters:
TICK_DIV, 5, clk cycles per one-second tick (≥2)
MAX_HOUR, 23, largest loadable hour value

Ports:
clk  input  1  clock
rst  input  1  reset
load  input  1  load ld_hour/ld_min/ld_sec and go idle
ld_sec  input  8  seconds to load
ld_min  input  8  minutes to load
ld_hour  input  8  hours to load
start  input  1  start or resume countdown
pause  input  1  pause countdown
sec  output  8  current seconds 0..59
min  output  8  current minutes 0..59
hour  output  8  current hours 0..MAX_HOUR
running  output  1  high while in RUN
done  output  1  one-cycle pulse on reaching zero
expired  output  1  high while in EXPIRED

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All outputs are registered.
- Reset values: sec=min=hour=0, running=0, done=0, expired=0, prescaler=0, state IDLE.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Priority each cycle: rst > load > pause > start > tick.
- load (any state):
  - Time is loaded with clamping: sec=min(ld_sec,59), min=min(ld_min,59), hour=min(ld_hour,MAX_HOUR).
  - Prescaler clears; state goes to IDLE; done=0.
  - Load during RUN aborts the countdown.
- start:
  - In IDLE, moves to RUN only if time≠0 and prescaler clears.
  - In PAUSED, moves to RUN with the prescaler retained (resume).
  - Ignored in RUN and EXPIRED.
  - start with time=0 in IDLE is ignored.
- pause:
  - In RUN, moves to PAUSED. That cycle the prescaler holds and no decrement occurs.
  - Ignored elsewhere. pause+start together in RUN gives PAUSED.
- Prescaler:
  - Counts 0..TICK_DIV-1, advancing only on RUN cycles with no pause/load.
  - The tick fires when prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - First decrement is visible TICK_DIV cycles after running rises.
- Decrement on tick:
  - If sec>0: sec-1.
  - Else if min>0: min-1, sec=59.
  - Else if hour>0: hour-1, min=59, sec=59.
  - If the result is 00:00:00, the same edge sets state EXPIRED, done=1 for exactly one cycle, expired=1, running=0.
- EXPIRED: time stays 0 and expired stays high until load or rst. There is no wrap below zero.
- running = (state==RUN). expired = (state==EXPIRED).
- Arithmetic: 8-bit unsigned. Values never exceed 59/59/MAX_HOUR, because loads are clamped.
- rst mid-count: all state, time and the prescaler return to reset values on the next edge.

Decomposition:
- Shared package digi_clock_pkg:
  - state enum {IDLE, RUN, PAUSED, EXPIRED}
  - SEC_MAX=59, MIN_MAX=59, TIME_W=8
  - The package is shared with the up-counting clock.
- Sub-module digi_tick_prescaler:
  - Parameter TICK_DIV.
  - Inputs clk, rst, clr, en.
  - Output tick, combinational on count==TICK_DIV-1 && en.
- Top level holds the FSM and the borrow chain.

Test Plan:
- Reset then load 0:0:3, start (TICK_DIV=5) -> running=1; sec 3→2→1→0 at 5-cycle spacing; done pulses 1 cycle on the 0 edge; expired=1; running=0.
- Load 1:00:00, start, one tick -> hour=0, min=59, sec=59. Load 0:1:0, one tick -> 0:0:59.
- Load 0:0:10, start, pause after 7 cycles (sec=9, prescaler=2), hold 20 cycles -> sec stays 9. Then start -> next decrement 3 cycles later (prescaler retained).
- Load ld_hour=99, ld_min=75, ld_sec=200 -> 23:59:59. Load 0:0:0 then start -> stays IDLE, running=0, done never pulses.
- During RUN at 0:0:5, load 0:2:0 -> next cycle IDLE with 0:2:0, prescaler=0, no decrement until start.
- EXPIRED with start asserted -> no change. rst asserted mid-RUN -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/digi_clock_pkg.sv
// Shared types and limits for the digital clock family.
// Used by both the up-counting clock and the countdown timer.
package digi_clock_pkg;

  localparam int TIME_W  = 8;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  function automatic logic [TIME_W-1:0] clamp(
    input logic [TIME_W-1:0] v,
    input logic [TIME_W-1:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/digi_tick_prescaler.sv
// Divides clk into one-second ticks.
// Counts only while enabled; tick is high on the last count.
module digi_tick_prescaler #(
  parameter int TICK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/digi_countdown_timer.sv
// HH:MM:SS countdown timer with load, start, pause/resume.
// Pulses done and latches expired on reaching 00:00:00.
module digi_countdown_timer
  import digi_clock_pkg::*;
#(
  parameter int TICK_DIV = 5,
  parameter int MAX_HOUR = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] ld_sec,
  input  logic [TIME_W-1:0] ld_min,
  input  logic [TIME_W-1:0] ld_hour,
  input  logic              start,
  input  logic              pause,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] hour,
  output logic              running,
  output logic              done,
  output logic              expired
);

  localparam logic [TIME_W-1:0] S_MAX = TIME_W'(SEC_MAX);
  localparam logic [TIME_W-1:0] M_MAX = TIME_W'(MIN_MAX);
  localparam logic [TIME_W-1:0] H_MAX = TIME_W'(MAX_HOUR);

  state_t state, state_nx;
  logic [TIME_W-1:0] sec_nx, min_nx, hour_nx;
  logic done_nx;
  logic is_zero;
  logic pre_clr, pre_en, tick;

  digi_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (pre_en),
    .tick(tick)
  );

  assign is_zero = (sec == '0) && (min == '0) && (hour == '0);
  assign pre_en  = (state == RUN) && !pause && !load;

  always_comb begin
    state_nx = state;
    sec_nx   = sec;
    min_nx   = min;
    hour_nx  = hour;
    done_nx  = 1'b0;
    pre_clr  = 1'b0;
    if (load) begin
      sec_nx   = clamp(ld_sec, S_MAX);
      min_nx   = clamp(ld_min, M_MAX);
      hour_nx  = clamp(ld_hour, H_MAX);
      state_nx = IDLE;
      pre_clr  = 1'b1;
    end else if (pause && state == RUN) begin
      state_nx = PAUSED;
    end else if (start && state == IDLE && !is_zero) begin
      state_nx = RUN;
      pre_clr  = 1'b1;
    end else if (start && state == PAUSED) begin
      state_nx = RUN;
    end else if (tick) begin
      if (sec != '0) begin
        sec_nx = sec - 1'b1;
        // Only 00:00:01 can borrow down to zero.
        if (sec == 8'd1 && min == '0 && hour == '0) begin
          state_nx = EXPIRED;
          done_nx  = 1'b1;
        end
      end else if (min != '0) begin
        min_nx = min - 1'b1;
        sec_nx = S_MAX;
      end else if (hour != '0) begin
        hour_nx = hour - 1'b1;
        min_nx  = M_MAX;
        sec_nx  = S_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      done    <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      sec     <= sec_nx;
      min     <= min_nx;
      hour    <= hour_nx;
      done    <= done_nx;
      running <= (state_nx == RUN);
      expired <= (state_nx == EXPIRED);
    end
  end

endmodule

// File: tb/tb_digi_countdown_timer.sv
// Bench for digi_countdown_timer: directed plan plus random
// traffic checked against a total-seconds reference model.
module tb_digi_countdown_timer;

  localparam int DIV = 5;
  localparam int MH  = 23;

  logic       clk = 1'b0;
  logic       rst, load, start, pause;
  logic [7:0] ld_sec, ld_min, ld_hour;
  logic [7:0] sec, min, hour;
  logic       running, done, expired;

  int tests = 0;
  int fails = 0;

  // model: mode 0 idle, 1 run, 2 paused, 3 expired
  int m_t, m_mode, m_pre;
  bit m_done;

  always #5 clk = ~clk;

  digi_countdown_timer #(
    .TICK_DIV(DIV),
    .MAX_HOUR(MH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .ld_sec (ld_sec),
    .ld_min (ld_min),
    .ld_hour(ld_hour),
    .start  (start),
    .pause  (pause),
    .sec    (sec),
    .min    (min),
    .hour   (hour),
    .running(running),
    .done   (done),
    .expired(expired)
  );

  function automatic int lim(input int v, input int l);
    return (v > l) ? l : v;
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (rst) begin
      m_t = 0; m_mode = 0; m_pre = 0;
    end else if (load) begin
      m_t = lim(ld_hour, MH) * 3600 + lim(ld_min, 59) * 60
          + lim(ld_sec, 59);
      m_mode = 0; m_pre = 0;
    end else if (pause && m_mode == 1) begin
      m_mode = 2;
    end else if (start && m_mode == 0 && m_t != 0) begin
      m_mode = 1; m_pre = 0;
    end else if (start && m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_pre == DIV - 1) begin
        m_pre = 0;
        m_t   = m_t - 1;
        if (m_t == 0) begin
          m_mode = 3; m_done = 1'b1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] o,
                      input int e);
    tests++;
    assert (o === 8'(e)) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input bit e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, o, e);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk8("hour", hour, m_t / 3600);
    chk8("min", min, (m_t % 3600) / 60);
    chk8("sec", sec, m_t % 60);
    chk1("running", running, m_mode == 1);
    chk1("done", done, m_done);
    chk1("expired", expired, m_mode == 3);
    rst = 0; load = 0; start = 0; pause = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; ld_hour = 8'(h); ld_min = 8'(m); ld_sec = 8'(s);
    cyc();
  endtask

  task automatic do_start();
    start = 1;
    cyc();
  endtask

  initial begin
    rst = 1; load = 0; start = 0; pause = 0;
    ld_sec = 0; ld_min = 0; ld_hour = 0;
    m_t = 0; m_mode = 0; m_pre = 0; m_done = 0;
    rst = 1; cyc();
    rst = 1; cyc();

    do_load(0, 0, 3);
    do_start();
    chk1("run_rise", running, 1'b1);
    idle(16);
    chk1("exp_3s", expired, 1'b1);

    do_load(1, 0, 0);
    do_start();
    idle(DIV);
    chk8("borrow_h", hour, 0);
    chk8("borrow_m", min, 59);
    chk8("borrow_s", sec, 59);

    do_load(0, 1, 0);
    do_start();
    idle(DIV);
    chk8("borrow_ms", sec, 59);

    do_load(0, 0, 10);
    do_start();
    idle(7);
    pause = 1; cyc();
    idle(20);
    chk8("paused_s", sec, 9);
    do_start();
    idle(2);
    chk8("resume_hold", sec, 9);
    idle(1);
    chk8("resume_dec", sec, 8);

    do_load(99, 75, 200);
    chk8("clamp_h", hour, 23);
    chk8("clamp_m", min, 59);
    chk8("clamp_s", sec, 59);

    do_load(0, 0, 0);
    do_start();
    idle(8);
    chk1("zero_start", running, 1'b0);

    do_load(0, 0, 5);
    do_start();
    idle(2);
    do_load(0, 2, 0);
    idle(10);
    chk8("abort_m", min, 2);

    pause = 1; start = 1; do_start();
    pause = 1; start = 1; cyc();
    chk1("pause_wins", running, 1'b0);

    do_load(0, 0, 1);
    do_start();
    idle(DIV + 1);
    start = 1; cyc();
    start = 1; cyc();
    chk1("exp_hold", expired, 1'b1);

    do_load(0, 5, 0);
    do_start();
    idle(3);
    rst = 1; cyc();
    chk8("rst_m", min, 0);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 5) == 0);
      ld_sec  = 8'($urandom_range(0, 70));
      ld_min  = 8'($urandom_range(0, 2));
      ld_hour = ($urandom_range(0, 9) == 0) ?
                8'($urandom_range(0, 40)) : 8'd0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
